// File: rtl/jt7759_cendiv_if.sv
// Bus between the clock-enable source and the ADPCM timing divider:
// enables and divisor request in, derived enables and period status out.
interface jt7759_cendiv_if #(
  parameter int DW = 6
);
  logic          cen;
  logic          restart;
  logic [DW-1:0] divby;
  logic          cen_ctl;
  logic          cen_dec;
  logic [DW-1:0] div_l;
  logic [DW-1:0] phase;

  modport master (
    output cen, restart, divby,
    input  cen_ctl, cen_dec, div_l, phase
  );

  modport slave (
    input  cen, restart, divby,
    output cen_ctl, cen_dec, div_l, phase
  );
endinterface

// File: rtl/jt7759_cendiv.sv
// ADPCM timing divider: prescaled decoder sample enable plus a control
// enable that either mirrors cen or runs at roughly half the decoder divisor.
module jt7759_cendiv #(
  parameter int DW       = 6,
  parameter int PRE      = 4,
  parameter int MINDIV   = 9,
  parameter int CTL_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  jt7759_cendiv_if.slave    io_if
);
  localparam int PW = $clog2(PRE);

  logic [PW-1:0] r_pre;
  logic [DW-1:0] r_dec;
  logic [DW-1:0] r_ctl;
  logic [DW-1:0] r_div;
  logic          r_cen_ctl;
  logic          r_cen_dec;

  logic          w_eop;
  logic          w_eoc_dec;
  logic          w_eoc_ctl;
  logic [DW-1:0] w_div_req;

  assign w_eop     = (r_pre == PW'(PRE-1));
  assign w_eoc_dec = (r_dec == r_div) && w_eop;
  assign w_eoc_ctl = (r_ctl == (r_div >> 1));
  assign w_div_req = (io_if.divby < DW'(MINDIV)) ? DW'(MINDIV) : io_if.divby;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre     <= '0;
      r_dec     <= '0;
      r_ctl     <= '0;
      r_div     <= DW'(MINDIV);
      r_cen_ctl <= 1'b0;
      r_cen_dec <= 1'b0;
    end else if (io_if.restart) begin
      // restart swallows a coincident cen and re-samples the divisor
      r_pre     <= '0;
      r_dec     <= '0;
      r_ctl     <= '0;
      r_div     <= w_div_req;
      r_cen_ctl <= 1'b0;
      r_cen_dec <= 1'b0;
    end else begin
      r_cen_dec <= io_if.cen && w_eoc_dec;
      r_cen_ctl <= (CTL_MODE == 0) ? io_if.cen : (io_if.cen && w_eoc_ctl);
      if (io_if.cen) begin
        r_pre <= w_eop ? '0 : r_pre + 1'b1;
        if (w_eop)
          r_dec <= w_eoc_dec ? '0 : r_dec + 1'b1;
        if (w_eoc_dec)
          r_div <= w_div_req;
        // the decoder period end realigns the control phase as well
        r_ctl <= (w_eoc_ctl || w_eoc_dec) ? '0 : r_ctl + 1'b1;
      end
    end
  end

  assign io_if.cen_ctl = r_cen_ctl;
  assign io_if.cen_dec = r_cen_dec;
  assign io_if.div_l   = r_div;
  assign io_if.phase   = r_dec;
endmodule

// File: tb/tb_jt7759_cendiv.sv
// Directed bench for jt7759_cendiv: both control modes side by side against a
// pulse-counting reference model, plus literal period/phase expectations.
module tb_jt7759_cendiv;
  localparam int DW = 6, PRE = 4, MINDIV = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen = 1'b0;
  logic restart = 1'b0;
  logic [DW-1:0] divby = 6'd9;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  jt7759_cendiv_if #(.DW(DW)) if0 ();
  jt7759_cendiv_if #(.DW(DW)) if1 ();

  assign if0.cen = cen;  assign if0.restart = restart;  assign if0.divby = divby;
  assign if1.cen = cen;  assign if1.restart = restart;  assign if1.divby = divby;

  jt7759_cendiv #(.DW(DW), .PRE(PRE), .MINDIV(MINDIV), .CTL_MODE(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .io_if(if0.slave));
  jt7759_cendiv #(.DW(DW), .PRE(PRE), .MINDIV(MINDIV), .CTL_MODE(1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .io_if(if1.slave));

  // Reference: count cen pulses inside the decoder period and since the last
  // control pulse; compare against the period lengths directly.
  int m_cnt, m_ccnt, m_div;
  bit e_dec, e_ctl0, e_ctl1;
  int e_phase, e_div;

  function automatic int clampd(input int d);
    return (d < MINDIV) ? MINDIV : d;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt = 0; m_ccnt = 0; m_div = MINDIV;
      e_dec = 0; e_ctl0 = 0; e_ctl1 = 0;
    end else if (restart) begin
      m_cnt = 0; m_ccnt = 0; m_div = clampd(int'(divby));
      e_dec = 0; e_ctl0 = 0; e_ctl1 = 0;
    end else begin
      e_dec = 0; e_ctl0 = cen; e_ctl1 = 0;
      if (cen) begin
        m_cnt++;
        m_ccnt++;
        if (m_ccnt == (m_div / 2) + 1) begin
          e_ctl1 = 1; m_ccnt = 0;
        end
        if (m_cnt == PRE * (m_div + 1)) begin
          e_dec = 1; m_cnt = 0; m_ccnt = 0; m_div = clampd(int'(divby));
        end
      end
    end
    e_phase = m_cnt / PRE;
    e_div   = m_div;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m0.cen_dec", int'(if0.cen_dec), int'(e_dec));
      check("m0.cen_ctl", int'(if0.cen_ctl), int'(e_ctl0));
      check("m0.phase",   int'(if0.phase),   e_phase);
      check("m0.div_l",   int'(if0.div_l),   e_div);
      check("m1.cen_dec", int'(if1.cen_dec), int'(e_dec));
      check("m1.cen_ctl", int'(if1.cen_ctl), int'(e_ctl1));
      check("m1.phase",   int'(if1.phase),   e_phase);
      check("m1.div_l",   int'(if1.div_l),   e_div);
    end
  end

  // one cen pulse from a negedge, followed by idle low cycles (<0: random 0..6)
  task automatic cen_pulse(input int idle, output bit dec, output bit ctl1);
    int k;
    cen = 1'b1;
    @(negedge clk);
    cen = 1'b0;
    dec  = if0.cen_dec;
    ctl1 = if1.cen_ctl;
    k = (idle < 0) ? int'($urandom_range(0, 6)) : idle;
    repeat (k) @(negedge clk);
  endtask

  task automatic pulses(input int num, input int idle);
    bit d, c;
    for (int i = 0; i < num; i++) cen_pulse(idle, d, c);
  endtask

  // cen pulses up to and including the one that yields cen_dec
  task automatic run_period(input int idle, output int n, output int nctl, output int fctl);
    bit d, c;
    n = 0; nctl = 0; fctl = 0; d = 0;
    while (n < 200 && !d) begin
      cen_pulse(idle, d, c);
      n++;
      if (c) begin
        nctl++;
        if (fctl == 0) fctl = n;
      end
    end
    if (!d) check("period_timeout", n, -1);
  endtask

  int n, nc, fc;

  initial begin
    @(negedge clk);
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst.phase", int'(if0.phase), 0);
    check("rst.div_l", int'(if0.div_l), MINDIV);
    check("rst.cen_dec", int'(if0.cen_dec), 0);
    rst_n = 1'b1;

    // S1: nominal period, cen every 2 clk; mode-1 ctl every 5 cen, 40 = 8*5
    run_period(1, n, nc, fc);
    check("s1.first_period", n, 40);
    run_period(1, n, nc, fc);
    check("s1.period", n, 40);
    check("s1.m1_ctl_pulses", nc, 8);
    check("s1.m1_first_ctl", fc, 5);

    // S2: divisors below the floor clamp
    divby = 6'd3;
    run_period(1, n, nc, fc);
    check("s2.period_div3", n, 40);
    check("s2.div_l_div3", int'(if0.div_l), 9);
    divby = 6'd0;
    run_period(1, n, nc, fc);
    check("s2.period_div0", n, 40);
    check("s2.div_l_div0", int'(if0.div_l), 9);

    // S3: mid-period divisor change only takes effect at the period end
    divby = 6'd9;
    pulses(16, 1);
    check("s3.phase4", int'(if0.phase), 4);
    divby = 6'd20;
    run_period(1, n, nc, fc);
    check("s3.rest_of_period", n, 24);
    check("s3.div_l20", int'(if0.div_l), 20);
    divby = 6'd12;
    run_period(1, n, nc, fc);
    check("s3.period84", n, 84);

    // S4: divisor 12, mode-1 ctl every 7 cen, realigned each 52-cen period
    check("s4.div_l12", int'(if1.div_l), 12);
    run_period(1, n, nc, fc);
    check("s4.period52", n, 52);
    check("s4.m1_ctl_pulses", nc, 7);
    check("s4.m1_first_ctl", fc, 7);
    run_period(0, n, nc, fc);
    check("s4.period52_b2b", n, 52);
    check("s4.m1_first_ctl_b", fc, 7);

    // S5: restart coincident with cen
    divby = 6'd15;
    pulses(20, 1);
    check("s5.phase5", int'(if0.phase), 5);
    restart = 1'b1; cen = 1'b1;
    @(negedge clk);
    restart = 1'b0; cen = 1'b0;
    check("s5.cen_dec", int'(if0.cen_dec), 0);
    check("s5.cen_ctl_m0", int'(if0.cen_ctl), 0);
    check("s5.phase0", int'(if0.phase), 0);
    check("s5.div_l15", int'(if0.div_l), 15);
    run_period(1, n, nc, fc);
    check("s5.period64", n, 64);

    // S6: reset mid-period with cen high, then random cen gaps
    divby = 6'd9;
    pulses(10, 1);
    rst_n = 1'b0; cen = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; cen = 1'b0;
    check("s6.cen_dec", int'(if0.cen_dec), 0);
    check("s6.cen_ctl_m0", int'(if0.cen_ctl), 0);
    check("s6.phase0", int'(if0.phase), 0);
    check("s6.div_l", int'(if0.div_l), MINDIV);
    run_period(1, n, nc, fc);
    check("s6.recover_period", n, 40);
    check("s6.m1_ctl_pulses", nc, 8);
    run_period(-1, n, nc, fc);
    check("s6.rand_period_a", n, 40);
    run_period(-1, n, nc, fc);
    check("s6.rand_period_b", n, 40);
    check("s6.m1_ctl_rand", nc, 8);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
